// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan path.
package display_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int SEL_W      = 2;

    typedef logic [3:0] nibble_t;
    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} slot_state_e;

    // A digit is a leading zero when it and every more-significant digit are 0;
    // digit 0 always stays lit so a zero value still shows "0".
    function automatic logic lz_blank(input logic [4*NUM_DIGITS-1:0] v,
                                      input logic [SEL_W-1:0] k);
        logic b;
        b = (k != '0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(k) && v[4*i +: 4] != 4'h0) b = 1'b0;
        end
        return b;
    endfunction
endpackage

// File: rtl/display_scan_controller_if.sv
// Result-load and digit-drive signals between the counter core and the segment encoder.
interface display_scan_controller_if;
    import display_pkg::*;

    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    lz_suppress;
    logic [SEL_W-1:0]        sel;
    logic                    digit_en;
    nibble_t                 nibble;
    logic                    dp;
    logic                    pending;
    logic                    frame_tick;

    modport master (output value_in, dp_in, load, lz_suppress,
                    input  sel, digit_en, nibble, dp, pending, frame_tick);
    modport slave  (input  value_in, dp_in, load, lz_suppress,
                    output sel, digit_en, nibble, dp, pending, frame_tick);
endinterface

// File: rtl/scan_prescaler.sv
// Digit-slot timebase: counts 0..PRESCALE-1 and flags the end of dead time and of the slot.
module scan_prescaler #(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        slot_end,
    output logic                        blank_end,
    output logic [$clog2(PRESCALE)-1:0] cnt
);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BEND = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        slot_end  = (cnt_q == LAST);
        blank_end = (cnt_q == BEND);
        cnt_d     = slot_end ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/display_scan_controller.sv
// Four-digit scan controller: walks sel through the digits with dead time between slots
// and swaps in newly loaded results only at the 3->0 wrap so a frame never mixes values.
module display_scan_controller #(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 2000
) (
    input  logic                      clk,
    input  logic                      reset,
    display_scan_controller_if.slave  bus
);
    import display_pkg::*;

    localparam int CNT_W = $clog2(PRESCALE);

    logic             slot_end, blank_end;
    logic [CNT_W-1:0] cnt;

    scan_prescaler #(.PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK_CYCLES)) u_pre (
        .clk       (clk),
        .reset     (reset),
        .slot_end  (slot_end),
        .blank_end (blank_end),
        .cnt       (cnt)
    );

    slot_state_e             state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [4*NUM_DIGITS-1:0] shown_q, shown_d, hold_q, hold_d;
    logic [NUM_DIGITS-1:0]   shown_dp_q, shown_dp_d, hold_dp_q, hold_dp_d;
    logic                    pending_q, pending_d;
    logic                    digit_en_q, digit_en_d;
    nibble_t                 nibble_q, nibble_d;
    logic                    dp_q, dp_d;
    logic                    frame_tick_q, frame_tick_d;
    logic                    wrap;

    always_ff @(posedge clk) begin
        if (reset) state_q <= BLANK;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK:   if (blank_end) state_d = SHOW;
            SHOW:    if (slot_end)  state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

    always_comb begin
        wrap       = slot_end && (sel_q == SEL_W'(NUM_DIGITS - 1));
        sel_d      = slot_end ? sel_q + 1'b1 : sel_q;
        shown_d    = shown_q;
        shown_dp_d = shown_dp_q;
        hold_d     = hold_q;
        hold_dp_d  = hold_dp_q;
        pending_d  = pending_q;
        if (wrap) begin
            // A load landing exactly on the wrap bypasses staging.
            if (bus.load) begin
                shown_d    = bus.value_in;
                shown_dp_d = bus.dp_in;
            end else if (pending_q) begin
                shown_d    = hold_q;
                shown_dp_d = hold_dp_q;
            end
            pending_d = 1'b0;
        end else if (bus.load) begin
            hold_d    = bus.value_in;
            hold_dp_d = bus.dp_in;
            pending_d = 1'b1;
        end
        // digit_en follows the next state so it is already low in the cycle sel moves;
        // nibble/dp lag sel by one cycle, hidden by that dead time.
        digit_en_d   = (state_d == SHOW) && !(bus.lz_suppress && lz_blank(shown_q, sel_q));
        nibble_d     = shown_q[{sel_q, 2'b00} +: 4];
        dp_d         = shown_dp_q[sel_q];
        frame_tick_d = wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q        <= '0;
            shown_q      <= '0;
            shown_dp_q   <= '0;
            hold_q       <= '0;
            hold_dp_q    <= '0;
            pending_q    <= 1'b0;
            digit_en_q   <= 1'b0;
            nibble_q     <= '0;
            dp_q         <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            shown_q      <= shown_d;
            shown_dp_q   <= shown_dp_d;
            hold_q       <= hold_d;
            hold_dp_q    <= hold_dp_d;
            pending_q    <= pending_d;
            digit_en_q   <= digit_en_d;
            nibble_q     <= nibble_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Lit phase must never overlap the dead-time window of the slot.
    always_ff @(posedge clk) begin
        if (!reset && state_q == SHOW) assert (int'(cnt) >= BLANK_CYCLES);
    end

    assign bus.sel        = sel_q;
    assign bus.digit_en   = digit_en_q;
    assign bus.nibble     = nibble_q;
    assign bus.dp         = dp_q;
    assign bus.pending    = pending_q;
    assign bus.frame_tick = frame_tick_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// Directed plus randomized bench for display_scan_controller against a time-indexed reference model.
module tb_display_scan_controller;
    localparam int P     = 8;
    localparam int B     = 2;
    localparam int FRAME = 4 * P;

    logic clk = 1'b0;
    logic reset;

    display_scan_controller_if bus();

    display_scan_controller #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          k;
    logic [15:0] m_shown, m_hold;
    logic [3:0]  m_sdp, m_hdp;
    logic        m_pend, was_reset, lz_cur;
    logic        prev_en;
    logic [1:0]  prev_sel;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    // Model: after k edges out of reset, slot = k/P, position = k%P; results swap every FRAME edges.
    task automatic check_outputs(input logic lz);
        int   s, c;
        logic blank;
        s     = (k / P) % 4;
        c     = k % P;
        blank = lz && s > 0 && (16'(m_shown >> (4 * s)) == 16'd0);
        chk("sel",        16'(bus.sel),        16'(s));
        chk("digit_en",   16'(bus.digit_en),   16'((c >= B) && !blank));
        chk("frame_tick", 16'(bus.frame_tick), 16'(k > 0 && k % FRAME == 0));
        chk("pending",    16'(bus.pending),    16'(m_pend));
        if (was_reset) begin
            chk("nibble_rst", 16'(bus.nibble), 16'h0);
            chk("dp_rst",     16'(bus.dp),     16'h0);
        end else if (c != 0) begin
            chk("nibble", 16'(bus.nibble), 16'(m_shown[4*s +: 4]));
            chk("dp",     16'(bus.dp),     16'(m_sdp[s]));
        end
        if (!was_reset && prev_en && bus.digit_en)
            chk("decoder_stable_while_lit", 16'(bus.sel), 16'(prev_sel));
        prev_en  = bus.digit_en;
        prev_sel = bus.sel;
    endtask

    task automatic step(input logic rst, input logic ld, input logic [15:0] v,
                        input logic [3:0] d, input logic lz);
        reset           = rst;
        bus.load        = ld;
        bus.value_in    = v;
        bus.dp_in       = d;
        bus.lz_suppress = lz;
        @(posedge clk);
        if (rst) begin
            k = 0; m_shown = '0; m_hold = '0; m_sdp = '0; m_hdp = '0;
            m_pend = 1'b0; was_reset = 1'b1;
        end else begin
            k++;
            was_reset = 1'b0;
            if (k % FRAME == 0) begin
                if (ld) begin
                    m_shown = v; m_sdp = d;
                end else if (m_pend) begin
                    m_shown = m_hold; m_sdp = m_hdp;
                end
                m_pend = 1'b0;
            end else if (ld) begin
                m_hold = v; m_hdp = d; m_pend = 1'b1;
            end
        end
        @(negedge clk);
        check_outputs(lz);
    endtask

    // Idle cycles drive random data with load low: nothing may be captured.
    task automatic idle();
        step(1'b0, 1'b0, 16'($urandom), 4'($urandom), lz_cur);
    endtask

    initial begin
        reset = 1'b1; bus.load = 1'b0; bus.value_in = '0; bus.dp_in = '0; bus.lz_suppress = 1'b0;
        k = 0; m_shown = '0; m_hold = '0; m_sdp = '0; m_hdp = '0; m_pend = 1'b0;
        was_reset = 1'b1; lz_cur = 1'b0; prev_en = 1'b0; prev_sel = '0;

        // Reset and scan
        step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 16'h1234, 4'h0, 1'b0);
        step(1'b0, 1'b1, 16'h1234, 4'b0100, 1'b0);
        repeat (2 * FRAME) idle();

        // Tear-free load mid-frame while digit 1 is selected
        while (k % FRAME != P + 3) idle();
        step(1'b0, 1'b1, 16'hABCD, 4'b1010, 1'b0);
        repeat (2 * FRAME) idle();

        // Overwrite within one frame, then a load coincident with the wrap
        while (k % FRAME != 2) idle();
        step(1'b0, 1'b1, 16'h1111, 4'b0001, 1'b0);
        repeat (5) idle();
        step(1'b0, 1'b1, 16'h2222, 4'b0010, 1'b0);
        repeat (FRAME + 4) idle();
        while (k % FRAME != FRAME - 1) idle();
        step(1'b0, 1'b1, 16'h5555, 4'b1000, 1'b0);
        repeat (FRAME) idle();

        // Leading-zero suppression
        lz_cur = 1'b1;
        while (k % FRAME != 4) idle();
        step(1'b0, 1'b1, 16'h0070, 4'b1100, 1'b1);
        repeat (2 * FRAME) idle();
        step(1'b0, 1'b1, 16'h0000, 4'b0110, 1'b1);
        repeat (2 * FRAME) idle();
        lz_cur = 1'b0;

        // Reset while sel=2 with a load staged
        while (k % FRAME != 2 * P + 1) idle();
        step(1'b0, 1'b1, 16'h9876, 4'b1111, 1'b0);
        repeat (2) idle();
        step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
        repeat (FRAME + 2) idle();

        // Random loads, data and suppression mode
        for (int i = 0; i < 400; i++) begin
            if (k % FRAME == 0) lz_cur = 1'($urandom);
            step(1'b0, ($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom), lz_cur);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
